// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, init ROM and command decode for the LCD command sequencer.
//   state_e      sequencer phases (power-up wait, init bytes, host bytes)
//   INIT_STEPS   number of bytes in the power-on init sequence
//   init_byte    init ROM byte for a step
//   init_wait    ticks to wait after an init step (clear uses the long wait)
//   is_long_cmd  true for clear (0x01) and return-home (0x02/0x03) commands
package lcd_pkg;
  typedef enum logic [1:0] {PWR_WAIT, INIT, RUN} state_e;
  localparam int INIT_STEPS = 7;
  function automatic logic [7:0] init_byte(input logic [2:0] s);
    case (s)
      3'd4:    return 8'h0C;
      3'd5:    return 8'h01;
      3'd6:    return 8'h06;
      default: return 8'h38;
    endcase
  endfunction
  function automatic int init_wait(input logic [2:0] s, input int long_ticks);
    case (s)
      3'd0:    return 103;
      3'd1:    return 3;
      3'd5:    return long_ticks;
      default: return 1;
    endcase
  endfunction
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data[7:1] == 7'b0000001);
  endfunction
endpackage

// File: rtl/lcd_byte_fifo.sv
// lcd_byte_fifo: host byte FIFO ({rs, data}) with full/empty flags.
//   Clk, Reset     clock, synchronous active-high reset (flushes contents)
//   push_i, data_i write request and word; ignored while full
//   pop_i, data_o  read request and head word; ignored while empty
//   full_o, empty_o occupancy flags
module lcd_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge Clk) begin
    if (do_push && !Reset) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: HD44780 init sequence then host FIFO drain, one byte per Cuenta tick.
//   Clk, Reset            clock, synchronous active-high reset
//   Cuenta, enable        40 us tick and the E window that follows it
//   wr_valid/rs/data      host byte push; wr_ready = FIFO not full
//   LCD_RS/RW/DB/E        LCD bus (RW tied low, E = enable gated by e_gate)
//   init_done, busy       status
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int POWERUP_TICKS = 375,
  parameter int LONG_TICKS    = 41,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Cuenta,
  input  logic       enable,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DB,
  output logic       LCD_E,
  output logic       init_done,
  output logic       busy
);
  state_e state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [15:0] wait_q, wait_d, byte_w;
  logic e_gate_q, e_gate_d, rs_q, rs_d, done_q;
  logic [7:0] db_q, db_d, fifo_db, nxt_db;
  logic fifo_rs, fifo_full, fifo_empty, pop, issue, nxt_rs, in_run;
  lcd_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
    .Clk(Clk),
    .Reset(Reset),
    .push_i(wr_valid),
    .data_i({wr_rs, wr_data}),
    .pop_i(pop),
    .data_o({fifo_rs, fifo_db}),
    .full_o(fifo_full),
    .empty_o(fifo_empty)
  );
  assign wr_ready  = !fifo_full;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_DB    = db_q;
  assign LCD_E     = enable & e_gate_q;
  assign init_done = done_q;
  assign busy      = !done_q || wait_q != '0 || !fifo_empty;
  always_comb begin
    in_run   = state_q == RUN;
    issue    = Cuenta && wait_q == '0 && (!in_run || !fifo_empty);
    pop      = issue && in_run;
    nxt_rs   = in_run ? fifo_rs : 1'b0;
    nxt_db   = in_run ? fifo_db : init_byte(step_q);
    byte_w   = in_run ? (is_long_cmd(fifo_rs, fifo_db) ? 16'(LONG_TICKS) : 16'd1)
                      : 16'(init_wait(step_q, LONG_TICKS));
    rs_d     = issue ? nxt_rs : rs_q;
    db_d     = issue ? nxt_db : db_q;
    // e_gate stays high from an issuing tick until the next tick that does not issue
    e_gate_d = issue ? 1'b1 : (Cuenta ? 1'b0 : e_gate_q);
    wait_d   = issue ? byte_w - 16'd1 : ((Cuenta && wait_q != '0) ? wait_q - 16'd1 : wait_q);
    step_d   = (issue && !in_run) ? step_q + 3'd1 : step_q;
    state_d  = (issue && !in_run) ? (step_q == 3'(INIT_STEPS - 1) ? RUN : INIT) : state_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= PWR_WAIT;
      step_q   <= '0;
      wait_q   <= 16'(POWERUP_TICKS - 1);
      e_gate_q <= 1'b0;
      rs_q     <= 1'b0;
      db_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      wait_q   <= wait_d;
      e_gate_q <= e_gate_d;
      rs_q     <= rs_d;
      db_q     <= db_d;
      done_q   <= in_run;
    end
  end
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: random and directed stimulus against a tick-schedule reference model.
module tb_lcd_cmd_sequencer;
  localparam int PT = 375;
  localparam int LT = 41;
  localparam int FD = 8;
  localparam int P  = 6;
  logic Clk = 1'b0, Reset = 1'b1, Cuenta = 1'b0, enable = 1'b0;
  logic wr_valid = 1'b0, wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic wr_ready, LCD_RS, LCD_RW, LCD_E, init_done, busy;
  logic [7:0] LCD_DB;
  always #5 Clk = ~Clk;
  lcd_cmd_sequencer #(.POWERUP_TICKS(PT), .LONG_TICKS(LT), .FIFO_DEPTH(FD)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Cuenta(Cuenta),
    .enable(enable),
    .wr_valid(wr_valid),
    .wr_rs(wr_rs),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW),
    .LCD_DB(LCD_DB),
    .LCD_E(LCD_E),
    .init_done(init_done),
    .busy(busy)
  );
  int checks = 0, errors = 0;
  logic [8:0] q[$];
  int tcount = 0, next_ok = PT, init_idx = 0, phase = 0, rate = 0, first_e_tick = -1;
  int e_tick[256];
  logic m_rs = 1'b0, m_eg = 1'b0, m_done = 1'b0;
  logic [7:0] m_db = 8'h00;
  bit armed = 0, rst_req = 1, h_valid = 0;
  logic h_rs = 1'b0;
  logic [7:0] h_data = 8'h00;
  logic [7:0] rom_b[7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int rom_w[7] = '{103, 3, 1, 1, 1, LT, 1};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic int byte_wait(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? LT : 1;
  endfunction
  task automatic clk_cycle();
    bit tick, accept, new_done, issued;
    logic [8:0] b;
    @(negedge Clk);
    if (armed) begin
      chk("lcd_db", LCD_DB, m_db);
      chk("lcd_rs", LCD_RS, m_rs);
      chk("lcd_rw", LCD_RW, 0);
      chk("init_done", init_done, m_done);
      chk("busy", busy, !m_done || (next_ok - tcount - 1) > 0 || q.size() != 0);
      chk("wr_ready", wr_ready, q.size() < FD);
    end
    tick = phase == 0;
    Reset = rst_req;
    Cuenta = tick;
    enable = phase == 1 || phase == 2;
    wr_valid = h_valid;
    wr_rs = h_rs;
    wr_data = h_data;
    #1;
    if (armed) chk("lcd_e", LCD_E, enable && m_eg);
    if (armed && LCD_E === 1'b1 && phase == 1) begin
      e_tick[LCD_DB] = tcount;
      if (first_e_tick < 0) first_e_tick = tcount;
    end
    if (rst_req) begin
      q.delete();
      m_rs = 0; m_db = 0; m_eg = 0; m_done = 0;
      init_idx = 0; tcount = 0; next_ok = PT; first_e_tick = -1;
      armed = 1;
    end else begin
      accept = h_valid && q.size() < FD;
      new_done = init_idx == 7;
      if (tick) begin
        tcount++;
        issued = 0;
        if (tcount >= next_ok) begin
          if (init_idx < 7) begin
            m_rs = 0; m_db = rom_b[init_idx];
            next_ok = tcount + rom_w[init_idx];
            init_idx++;
            issued = 1;
          end else if (q.size() != 0) begin
            b = q.pop_front();
            m_rs = b[8]; m_db = b[7:0];
            next_ok = tcount + byte_wait(b[8], b[7:0]);
            issued = 1;
          end
        end
        m_eg = issued;
      end
      if (accept) begin
        q.push_back({h_rs, h_data});
        h_valid = 0;
      end
      m_done = new_done;
    end
    if (!h_valid && rate > $urandom_range(99)) begin
      h_valid = 1;
      h_rs = 1'($urandom_range(1));
      h_data = ($urandom_range(3) == 0) ? 8'($urandom_range(3)) : 8'($urandom_range(255));
    end
    phase = (phase + 1) % P;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_cycle();
  endtask
  task automatic push_byte(input logic rs, input logic [7:0] d);
    h_valid = 1; h_rs = rs; h_data = d;
    for (int i = 0; i < 5000 && h_valid; i++) clk_cycle();
    if (h_valid) begin
      chk("push_timeout", 1, 0);
      h_valid = 0;
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) e_tick[i] = 0;
    rst_req = 1;
    run(3);
    rst_req = 0;
    run(530 * P);
    chk("first_e_tick", first_e_tick, PT);
    chk("first_db", e_tick[8'h38] >= PT, 1);
    chk("init_done_up", init_done, 1);
    push_byte(1'b1, 8'h41);
    run(4 * P);
    chk("data_issued", e_tick[8'h41] != 0, 1);
    chk("busy_idle", busy, 0);
    push_byte(1'b0, 8'h01);
    push_byte(1'b1, 8'h42);
    run(50 * P);
    chk("long_gap", e_tick[8'h42] - e_tick[8'h01], LT);
    rst_req = 1;
    run(2);
    rst_req = 0;
    for (int i = 0; i < FD; i++) push_byte(1'b1, 8'(8'h60 + i));
    h_valid = 1; h_rs = 1'b1; h_data = 8'h68;
    @(posedge Clk);
    #1;
    chk("bp_ready", wr_ready, 0);
    run(545 * P);
    chk("bp_ninth", e_tick[8'h68] > e_tick[8'h67] && e_tick[8'h67] > e_tick[8'h60], 1);
    rate = 25;
    run(4000);
    rate = 0;
    run(2400);
    h_valid = 0;
    push_byte(1'b0, 8'h01);
    push_byte(1'b1, 8'h51);
    push_byte(1'b1, 8'h52);
    push_byte(1'b1, 8'h53);
    run(10 * P);
    chk("pre_rst_busy", busy, 1);
    rst_req = 1;
    clk_cycle();
    rst_req = 0;
    @(posedge Clk);
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_lcd_e", LCD_E, 0);
    chk("rst_ready", wr_ready, 1);
    run(380 * P);
    chk("rerun_first_e", first_e_tick, PT);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
